opm_write_sequencer: RTL and testbench

OPM_WRITE_SEQUENCER -- requirements
Module: opm_write_sequencer

---
 rtl/aura_pkg.sv | 50 +++++
 rtl/sync_fifo.sv | 75 +++++++
 rtl/opm_write_sequencer.sv | 175 +++++++++++++++++
 tb/tb_opm_write_sequencer.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aura_pkg.sv
// Shared definitions for the OPM write sequencer: FSM state encoding,
// status-bit index and the bus-control decode for each state.
package aura_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR_WR   = 3'd1,
    ST_ADDR_GAP  = 3'd2,
    ST_DATA_WR   = 3'd3,
    ST_DATA_GAP  = 3'd4,
    ST_BUSY_POLL = 3'd5
  } opm_state_e;

  // Bit of the OPM status byte that reports the chip is still busy
  localparam int unsigned STATUS_BUSY_BIT = 7;

  typedef struct packed {
    logic cs_n;
    logic wr_n;
    logic rd_n;
    logic a0;
  } opm_bus_t;

  // Active-low bus controls for a given state; everything parked high
  // outside the address/data strobes and the status read.
  function automatic opm_bus_t bus_ctrl(input opm_state_e st);
    opm_bus_t b;
    b = '1;
    case (st)
      ST_ADDR_WR: begin
        b.cs_n = 1'b0;
        b.wr_n = 1'b0;
        b.a0   = 1'b0;
      end
      ST_DATA_WR: begin
        b.cs_n = 1'b0;
        b.wr_n = 1'b0;
        b.a0   = 1'b1;
      end
      ST_BUSY_POLL: begin
        b.cs_n = 1'b0;
        b.rd_n = 1'b0;
        b.a0   = 1'b0;
      end
      default: b = '1;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count and a
// synchronous clear. A push while full is accepted only if a pop happens
// in the same cycle.
module sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [AW:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  // Pointer and occupancy update; clear wins over push/pop
  always_comb begin
    do_pop  = pop && (level_q != '0) && !clear;
    do_push = push && ((level_q != FULL_LVL) || do_pop) && !clear;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (clear) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage array, written on accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

  assign dout  = mem_q[rptr_q];
  assign full  = (level_q == FULL_LVL);
  assign empty = (level_q == '0);
  assign level = level_q;

endmodule

// File: rtl/opm_write_sequencer.sv
// Buffers host register writes and replays them on the OPM bus as an
// address strobe, a data strobe and a busy-flag poll, paced by phim_en.
module opm_write_sequencer
  import aura_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned STROBE_EN    = 2,
  parameter int unsigned BUSY_TIMEOUT = 1023
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          phim_en,
  input  logic                          wr_valid,
  input  logic [7:0]                    wr_addr,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  input  logic                          flush,
  output logic                          opm_cs_n,
  output logic                          opm_wr_n,
  output logic                          opm_rd_n,
  output logic                          opm_a0,
  output logic [7:0]                    opm_d,
  input  logic [7:0]                    opm_status,
  output logic                          idle,
  output logic                          timeout_err
);

  localparam int unsigned CNT_MAX = (BUSY_TIMEOUT > STROBE_EN) ? BUSY_TIMEOUT : STROBE_EN;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_EN - 1);
  localparam logic [CNT_W-1:0] POLL_LAST   = CNT_W'(BUSY_TIMEOUT - 1);

  opm_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic             tmo_q, tmo_d;

  logic             push, pop;
  logic [15:0]      fifo_dout;
  logic             fifo_full, fifo_empty;
  logic             busy;
  logic             unused_status;
  opm_bus_t         bus;

  assign busy          = opm_status[STATUS_BUSY_BIT];
  assign unused_status = ^opm_status;

  // A pop in this cycle frees a slot, so a full FIFO can still take a push
  assign wr_ready = !fifo_full || pop;
  assign push     = wr_valid && wr_ready && !flush;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .clear  (flush),
    .push   (push),
    .pop    (pop),
    .din    ({wr_addr, wr_data}),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  // Sequencing FSM: IDLE exit is free-running, every other step waits on phim_en
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    tmo_d   = tmo_q;
    pop     = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      tmo_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            pop              = 1'b1;
            {addr_d, data_d} = fifo_dout;
            cnt_d            = '0;
            state_d          = ST_ADDR_WR;
          end
        end
        ST_ADDR_WR: begin
          if (phim_en) begin
            if (cnt_q == STROBE_LAST) begin
              cnt_d   = '0;
              state_d = ST_ADDR_GAP;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_ADDR_GAP: begin
          if (phim_en) state_d = ST_DATA_WR;
        end
        ST_DATA_WR: begin
          if (phim_en) begin
            if (cnt_q == STROBE_LAST) begin
              cnt_d   = '0;
              state_d = ST_DATA_GAP;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_DATA_GAP: begin
          if (phim_en) state_d = ST_BUSY_POLL;
        end
        ST_BUSY_POLL: begin
          if (phim_en) begin
            if (!busy) begin
              cnt_d   = '0;
              state_d = ST_IDLE;
            end else if (cnt_q == POLL_LAST) begin
              cnt_d   = '0;
              tmo_d   = 1'b1;
              state_d = ST_IDLE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // FSM and latched-entry registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      tmo_q   <= tmo_d;
    end
  end

  // Bus outputs decode straight from the state register, so an async
  // reset or a flush parks the bus without waiting for another edge.
  always_comb begin
    bus = bus_ctrl(state_q);
    case (state_q)
      ST_ADDR_WR: opm_d = addr_q;
      ST_DATA_WR: opm_d = data_q;
      default:    opm_d = '0;
    endcase
  end

  assign opm_cs_n    = bus.cs_n;
  assign opm_wr_n    = bus.wr_n;
  assign opm_rd_n    = bus.rd_n;
  assign opm_a0      = bus.a0;
  assign idle        = fifo_empty && (state_q == ST_IDLE);
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_opm_write_sequencer.sv
// Self-checking bench for opm_write_sequencer: a bus monitor rebuilds each
// completed write from the strobes and the tests compare it against a queue
// of expected writes pushed as stimulus is driven.
module tb_opm_write_sequencer;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] ap;   // phim_en pulses in address strobe
    logic [7:0] gp;   // phim_en pulses in address/data gap
    logic [7:0] dp;   // phim_en pulses in data strobe
  } wr_rec_t;

  logic       clk, resetn, phim_en, wr_valid, wr_ready, flush;
  logic [7:0] wr_addr, wr_data, opm_d, opm_status;
  logic [4:0] fifo_level;
  logic       opm_cs_n, opm_wr_n, opm_rd_n, opm_a0, idle, timeout_err;

  int      n_tests = 0;
  int      n_fail  = 0;
  int      pulse_no = 0;
  int      busy_until = 0;
  bit      busy_stuck = 1'b0;
  int      poll_cnt = 0;
  int      excl_viol = 0;
  int      div = 0;
  int      ph = 0;
  wr_rec_t cur;
  wr_rec_t exp_q[$];
  wr_rec_t obs_q[$];

  opm_write_sequencer #(
    .FIFO_DEPTH   (16),
    .STROBE_EN    (2),
    .BUSY_TIMEOUT (1023)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .phim_en     (phim_en),
    .wr_valid    (wr_valid),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .fifo_level  (fifo_level),
    .flush       (flush),
    .opm_cs_n    (opm_cs_n),
    .opm_wr_n    (opm_wr_n),
    .opm_rd_n    (opm_rd_n),
    .opm_a0      (opm_a0),
    .opm_d       (opm_d),
    .opm_status  (opm_status),
    .idle        (idle),
    .timeout_err (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  // phim_en every 4th clock; busy bit driven from the test's request
  initial begin
    phim_en    = 1'b0;
    opm_status = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (phim_en) pulse_no++;
      div        = (div == 3) ? 0 : div + 1;
      phim_en    = (div == 3);
      opm_status = (busy_stuck || (pulse_no < busy_until)) ? 8'h80 : 8'h00;
    end
  end

  // Bus monitor: rebuilds writes from strobes, counts poll samples
  always @(negedge clk) begin
    if (!resetn) begin
      ph = 0;
    end else begin
      if (!opm_wr_n && !opm_rd_n) excl_viol++;
      if (opm_cs_n && (!opm_wr_n || !opm_rd_n)) excl_viol++;
      if (!opm_cs_n && !opm_wr_n && !opm_a0) begin
        if (ph != 1) begin
          ph = 1; cur.a = opm_d; cur.d = 8'h00;
          cur.ap = 8'd0; cur.gp = 8'd0; cur.dp = 8'd0;
        end
        if (phim_en) cur.ap = cur.ap + 8'd1;
      end else if (!opm_cs_n && !opm_wr_n && opm_a0) begin
        if (ph != 2) begin ph = 2; cur.d = opm_d; end
        if (phim_en) cur.dp = cur.dp + 8'd1;
      end else begin
        if (ph == 1) ph = 3;
        else if (ph == 2) begin obs_q.push_back(cur); ph = 0; end
        if (ph == 3 && phim_en) cur.gp = cur.gp + 8'd1;
      end
      if (!opm_cs_n && !opm_rd_n && phim_en) poll_cnt++;
    end
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  function automatic wr_rec_t mk(input logic [7:0] a, input logic [7:0] d);
    wr_rec_t r;
    r.a = a; r.d = d; r.ap = 8'd2; r.gp = 8'd1; r.dp = 8'd2;
    return r;
  endfunction

  task automatic push_one(input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic test_reset;
    #5 resetn = 1'b0;
    #3;
    n_tests++;
    if ({opm_cs_n, opm_wr_n, opm_rd_n, opm_a0} !== 4'hF) begin
      n_fail++; $display("FAIL reset_bus: got %b want 1111", {opm_cs_n, opm_wr_n, opm_rd_n, opm_a0});
    end
    n_tests++;
    if ({opm_d, fifo_level} !== 13'd0) begin
      n_fail++; $display("FAIL reset_d_level: got d=%h level=%0d want 0/0", opm_d, fifo_level);
    end
    n_tests++;
    if ({wr_ready, idle, timeout_err} !== 3'b110) begin
      n_fail++; $display("FAIL reset_flags: got rdy/idle/tmo=%b want 110", {wr_ready, idle, timeout_err});
    end
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic test_single_write;
    int pulses = 0;
    bit started = 0;
    bit done = 0;
    int p0 = poll_cnt;
    exp_q.push_back(mk(8'h20, 8'hC7));
    push_one(8'h20, 8'hC7);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!started && !opm_cs_n) started = 1;
      if (started) begin
        if (idle) begin done = 1; break; end
        if (phim_en) pulses++;
      end
    end
    n_tests++;
    if (!done || pulses != 7) begin
      n_fail++; $display("FAIL single_pulses: got done=%0d pulses=%0d want 1/7", done, pulses);
    end
    n_tests++;
    if (poll_cnt - p0 != 1) begin
      n_fail++; $display("FAIL single_polls: got %0d want 1", poll_cnt - p0);
    end
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL single_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      wr_rec_t e = exp_q.pop_front();
      wr_rec_t o = obs_q.pop_front();
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL single_rec: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back;
    busy_until = pulse_no + 30;
    exp_q.push_back(mk(8'h30, 8'h00));
    push_one(8'h30, 8'h00);
    for (int k = 0; k < 400; k++) begin
      if (opm_rd_n === 1'b0) break;
      @(negedge clk);
    end
    n_tests++;
    if (opm_rd_n !== 1'b0) begin n_fail++; $display("FAIL b2b_poll_start: got rd_n=%b want 0", opm_rd_n); end
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      wr_valid = 1'b1; wr_addr = 8'h40 + 8'(i); wr_data = 8'hA0 + 8'(i);
      exp_q.push_back(mk(wr_addr, wr_data));
      @(posedge clk); #1;
    end
    n_tests++;
    if (fifo_level !== 5'd16 || wr_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_full: got level=%0d ready=%b want 16/0", fifo_level, wr_ready);
    end
    wr_addr = 8'h7F; wr_data = 8'h55;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    n_tests++;
    if (fifo_level !== 5'd16) begin n_fail++; $display("FAIL b2b_drop: got level=%0d want 16", fifo_level); end
    for (int k = 0; k < 3000; k++) begin
      if (idle) break;
      @(negedge clk);
    end
    n_tests++;
    if (idle !== 1'b1) begin n_fail++; $display("FAIL b2b_drain: got idle=%b want 1", idle); end
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      wr_rec_t e = exp_q.pop_front();
      wr_rec_t o = obs_q.pop_front();
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL b2b_rec: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    n_tests++;
    if (timeout_err !== 1'b0 || excl_viol != 0) begin
      n_fail++; $display("FAIL b2b_flags: got tmo=%b viol=%0d want 0/0", timeout_err, excl_viol);
    end
  endtask

  task automatic test_timeout;
    int p0 = poll_cnt;
    busy_stuck = 1'b1;
    exp_q.push_back(mk(8'h28, 8'h11));
    push_one(8'h28, 8'h11);
    exp_q.push_back(mk(8'h29, 8'h22));
    push_one(8'h29, 8'h22);
    for (int k = 0; k < 6000; k++) begin
      if (timeout_err) break;
      @(negedge clk);
    end
    n_tests++;
    if (timeout_err !== 1'b1 || poll_cnt - p0 != 1023) begin
      n_fail++; $display("FAIL tmo_samples: got tmo=%b samples=%0d want 1/1023", timeout_err, poll_cnt - p0);
    end
    busy_stuck = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (idle) break;
      @(negedge clk);
    end
    n_tests++;
    if (idle !== 1'b1 || poll_cnt - p0 != 1024) begin
      n_fail++; $display("FAIL tmo_next: got idle=%b samples=%0d want 1/1024", idle, poll_cnt - p0);
    end
    n_tests++;
    if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b want 1", timeout_err); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      wr_rec_t e = exp_q.pop_front();
      wr_rec_t o = obs_q.pop_front();
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL tmo_rec: got %h want %h", o, e); end
    end
    n_tests++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_fail++; $display("FAIL tmo_count: got leftover exp=%0d obs=%0d want 0/0", exp_q.size(), obs_q.size());
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_flush;
    int p0;
    n_tests++;
    if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL flush_pre_tmo: got %b want 1", timeout_err); end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_addr = 8'h50 + 8'(i); wr_data = 8'h01 + 8'(i);
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (opm_wr_n === 1'b0 && opm_a0 === 1'b1) break;
      @(negedge clk);
    end
    n_tests++;
    if (opm_wr_n !== 1'b0 || opm_a0 !== 1'b1) begin
      n_fail++; $display("FAIL flush_data_wr: got wr_n=%b a0=%b want 0/1", opm_wr_n, opm_a0);
    end
    @(posedge clk); #1;
    flush = 1'b1; wr_valid = 1'b1; wr_addr = 8'h99; wr_data = 8'h99;
    @(posedge clk); #1;
    n_tests++;
    if ({opm_cs_n, opm_wr_n, opm_rd_n, opm_a0} !== 4'hF) begin
      n_fail++; $display("FAIL flush_bus: got %b want 1111", {opm_cs_n, opm_wr_n, opm_rd_n, opm_a0});
    end
    n_tests++;
    if (fifo_level !== 5'd0 || timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL flush_state: got level=%0d tmo=%b want 0/0", fifo_level, timeout_err);
    end
    flush = 1'b0; wr_valid = 1'b0;
    p0 = poll_cnt;
    repeat (60) @(posedge clk);
    #1;
    n_tests++;
    if (idle !== 1'b1 || poll_cnt != p0 || obs_q.size() > 1) begin
      n_fail++; $display("FAIL flush_quiet: got idle=%b polls=%0d recs=%0d want 1/0/<=1", idle, poll_cnt - p0, obs_q.size());
    end
    obs_q.delete();
    exp_q.push_back(mk(8'h60, 8'h66));
    push_one(8'h60, 8'h66);
    for (int k = 0; k < 400; k++) begin
      if (idle) break;
      @(negedge clk);
    end
    n_tests++;
    if (obs_q.size() != 1) begin n_fail++; $display("FAIL flush_after_count: got %0d want 1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      wr_rec_t e = exp_q.pop_front();
      wr_rec_t o = obs_q.pop_front();
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL flush_after_rec: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid_poll;
    int p0;
    busy_stuck = 1'b1;
    push_one(8'h70, 8'h77);
    push_one(8'h71, 8'h78);
    push_one(8'h72, 8'h79);
    for (int k = 0; k < 6000; k++) begin
      if (timeout_err) break;
      @(negedge clk);
    end
    for (int k = 0; k < 400; k++) begin
      if (opm_rd_n === 1'b0) break;
      @(negedge clk);
    end
    n_tests++;
    if (timeout_err !== 1'b1 || opm_rd_n !== 1'b0 || fifo_level !== 5'd1) begin
      n_fail++; $display("FAIL rst_pre: got tmo=%b rd_n=%b level=%0d want 1/0/1", timeout_err, opm_rd_n, fifo_level);
    end
    @(posedge clk);
    #7 resetn = 1'b0;
    #1;
    n_tests++;
    if ({opm_cs_n, opm_wr_n, opm_rd_n, opm_a0} !== 4'hF || opm_d !== 8'h00) begin
      n_fail++; $display("FAIL rst_async_bus: got %b d=%h want 1111 d=00", {opm_cs_n, opm_wr_n, opm_rd_n, opm_a0}, opm_d);
    end
    n_tests++;
    if (fifo_level !== 5'd0 || {wr_ready, idle, timeout_err} !== 3'b110) begin
      n_fail++; $display("FAIL rst_async_flags: got level=%0d rdy/idle/tmo=%b want 0/110", fifo_level, {wr_ready, idle, timeout_err});
    end
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    busy_stuck = 1'b0;
    obs_q.delete(); exp_q.delete();
    p0 = poll_cnt;
    repeat (60) @(posedge clk);
    #1;
    n_tests++;
    if (idle !== 1'b1 || poll_cnt != p0 || obs_q.size() != 0) begin
      n_fail++; $display("FAIL rst_quiet: got idle=%b polls=%0d recs=%0d want 1/0/0", idle, poll_cnt - p0, obs_q.size());
    end
  endtask

  task automatic test_push_pop_full;
    bit got = 0;
    logic [4:0] lvl_before;
    busy_stuck = 1'b1;
    exp_q.push_back(mk(8'h80, 8'h00));
    push_one(8'h80, 8'h00);
    for (int k = 0; k < 400; k++) begin
      if (opm_rd_n === 1'b0) break;
      @(negedge clk);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      wr_valid = 1'b1; wr_addr = 8'h81 + 8'(i); wr_data = 8'hB0 + 8'(i);
      exp_q.push_back(mk(wr_addr, wr_data));
      @(posedge clk); #1;
    end
    wr_addr = 8'h91; wr_data = 8'hC0;
    n_tests++;
    if (fifo_level !== 5'd16 || wr_ready !== 1'b0) begin
      n_fail++; $display("FAIL pp_full: got level=%0d ready=%b want 16/0", fifo_level, wr_ready);
    end
    busy_stuck = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (wr_ready === 1'b1) begin got = 1; break; end
      @(posedge clk); #1;
    end
    lvl_before = fifo_level;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    exp_q.push_back(mk(8'h91, 8'hC0));
    n_tests++;
    if (!got || lvl_before !== 5'd16 || fifo_level !== 5'd16) begin
      n_fail++; $display("FAIL pp_level: got ready=%0d before=%0d after=%0d want 1/16/16", got, lvl_before, fifo_level);
    end
    for (int k = 0; k < 3000; k++) begin
      if (idle) break;
      @(negedge clk);
    end
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL pp_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      wr_rec_t e = exp_q.pop_front();
      wr_rec_t o = obs_q.pop_front();
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL pp_rec: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    n_tests++;
    if (excl_viol != 0) begin n_fail++; $display("FAIL bus_exclusive: got %0d violations want 0", excl_viol); end
  endtask

  initial begin
    resetn = 1'b1; flush = 1'b0; wr_valid = 1'b0; wr_addr = 8'h00; wr_data = 8'h00;
    test_reset();
    test_single_write();
    test_back_to_back();
    test_timeout();
    test_flush();
    test_reset_mid_poll();
    test_push_pop_full();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
